puf_resp_reader: RTL and testbench

//  Control and readout for a bank of WIDTH ld/clr response latches.
//  On start, it sequences clear -> load -> settle and snapshots the latch outputs.
//  It then serialises the snapshot LSB-first over a valid/ready stream to the PUF

---
 rtl/puf_pkg.sv | 37 +++
 rtl/puf_resp_reader_if.sv | 10 +
 rtl/puf_sync2.sv | 26 ++
 rtl/puf_resp_reader.sv | 151 +++++++++++++++
 tb/tb_puf_resp_reader.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF response reader: FSM state encoding,
// default bank width / strobe timing, and width helpers for counters and indices.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD   = 3'd2,
        SETTLE = 3'd3,
        SHIFT  = 3'd4,
        FIN    = 3'd5
    } puf_state_e;

    localparam int unsigned PUF_WIDTH         = 16;
    localparam int unsigned PUF_CLR_CYCLES    = 2;
    localparam int unsigned PUF_LD_CYCLES     = 1;
    localparam int unsigned PUF_SETTLE_CYCLES = 4;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // clog2 helper that never yields a zero-width vector (WIDTH=1 is legal).
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Phase counter must hold the largest terminal value (param-1).
    function automatic int unsigned cnt_width(input int unsigned clr, input int unsigned ld,
                                              input int unsigned settle);
        return clog2_min1(max3(clr, ld, settle) + 1);
    endfunction

endpackage

// File: rtl/puf_resp_reader_if.sv
// Serial valid/ready response stream from the reader to the post-processing/UART path.
interface puf_resp_reader_if;
    logic tx_data;
    logic tx_valid;
    logic tx_ready;
    logic tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/puf_sync2.sv
// WIDTH-bit two-flop synchroniser for the latch outputs, which are asynchronous to clk.
module puf_sync2 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments and the async active-low
    // reset in the sensitivity list, so every flop clears the instant rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/puf_resp_reader.sv
// Sequences clear -> load -> settle on a bank of PUF response latches, snapshots the
// synchronised latch outputs and streams the snapshot LSB-first over valid/ready.
module puf_resp_reader
    import puf_pkg::*;
#(
    parameter int unsigned WIDTH         = PUF_WIDTH,
    parameter int unsigned CLR_CYCLES    = PUF_CLR_CYCLES,
    parameter int unsigned LD_CYCLES     = PUF_LD_CYCLES,
    parameter int unsigned SETTLE_CYCLES = PUF_SETTLE_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                lat_clr,
    output logic                lat_ld,
    input  logic [WIDTH-1:0]    lat_q,
    output logic                busy,
    output logic                done,
    puf_resp_reader_if.master   tx
);
    localparam int unsigned CNT_W = cnt_width(CLR_CYCLES, LD_CYCLES, SETTLE_CYCLES);
    localparam int unsigned IDX_W = clog2_min1(WIDTH);

    localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_LAST     = CNT_W'(LD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WIDTH - 1);

    puf_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             lat_clr_q, lat_clr_d;
    logic             lat_ld_q, lat_ld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_data_q, tx_data_d;
    logic             tx_last_q, tx_last_d;

    logic [WIDTH-1:0] sync_q;
    logic             accept;

    puf_sync2 #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (lat_q),
        .q     (sync_q)
    );

    assign accept = tx_valid_q && tx.tx_ready;

    // NOTE: every signal written here gets a default first; a missed branch would
    // otherwise infer a latch instead of holding the registered value.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD: begin
                if (cnt_q == LD_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    shreg_d   = sync_q;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (accept) begin
                    shreg_d = shreg_q >> 1;
                    // Index stops at the MSB so it never wraps within a response.
                    if (bit_idx_q == LAST_IDX) state_d = FIN;
                    else                       bit_idx_d = bit_idx_q + IDX_W'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs decoded from the next state so they come straight from flops.
        lat_clr_d  = (state_d == CLEAR);
        lat_ld_d   = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FIN);
        tx_valid_d = (state_d == SHIFT);
        tx_data_d  = tx_valid_d && shreg_d[0];
        tx_last_d  = tx_valid_d && (bit_idx_d == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            lat_clr_q  <= 1'b0;
            lat_ld_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            lat_clr_q  <= lat_clr_d;
            lat_ld_q   <= lat_ld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
        end
    end

    assign lat_clr     = lat_clr_q;
    assign lat_ld      = lat_ld_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_last  = tx_last_q;
endmodule

// File: tb/tb_puf_resp_reader.sv
// Scoreboard bench for puf_resp_reader: a set-only latch bank model feeds lat_q and the
// expected serial beats are queued at start and popped on every accepted handshake.
module tb_puf_resp_reader;
    localparam int W = 16;

    typedef struct packed {
        logic data;
        logic last;
    } beat_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         lat_clr, lat_ld, busy, done;
    logic [W-1:0] lat_q;
    logic [W-1:0] lat_bank = '0;
    logic [W-1:0] load_val = '0;

    puf_resp_reader_if tx_if ();

    int    tests = 0;
    int    fails = 0;
    beat_t exp_q[$];
    int    acc_cnt = 0, done_cnt = 0, clr_cnt = 0, ld_cnt = 0;
    logic  prev_hold = 1'b0, prev_data = 1'b0, prev_last = 1'b0;

    always #5 clk = ~clk;

    puf_resp_reader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .lat_clr (lat_clr),
        .lat_ld  (lat_ld),
        .lat_q   (lat_q),
        .busy    (busy),
        .done    (done),
        .tx      (tx_if)
    );

    // Latches only ever set on load; clearing them is the reader's job.
    always @(posedge clk) begin
        if (lat_clr)     lat_bank <= '0;
        else if (lat_ld) lat_bank <= lat_bank | load_val;
    end
    assign lat_q = lat_bank;

    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(lat_clr && lat_ld))
        else begin
            fails++;
            $display("FAIL strobe_excl: lat_clr=%b lat_ld=%b, required not both 1", lat_clr, lat_ld);
        end

    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (lat_clr) clr_cnt++;
            if (lat_ld)  ld_cnt++;
            if (done)    done_cnt++;
            if (prev_hold) begin
                tests++;
                if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== prev_data || tx_if.tx_last !== prev_last) begin
                    fails++;
                    $display("FAIL hold_stable: valid/data/last=%b%b%b, required 1%b%b",
                             tx_if.tx_valid, tx_if.tx_data, tx_if.tx_last, prev_data, prev_last);
                end
            end
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                acc_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_beat: data=%b last=%b, required no beat", tx_if.tx_data, tx_if.tx_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({tx_if.tx_data, tx_if.tx_last} !== {e.data, e.last}) begin
                        fails++;
                        $display("FAIL beat %0d: data/last=%b%b, required %b%b",
                                 acc_cnt - 1, tx_if.tx_data, tx_if.tx_last, e.data, e.last);
                    end
                end
            end
            prev_hold = tx_if.tx_valid && !tx_if.tx_ready;
            prev_data = tx_if.tx_data;
            prev_last = tx_if.tx_last;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Cycle n is the cycle after the n-th edge counted from the edge that samples start.
    task automatic run_stream(input logic [W-1:0] val, input bit toggle,
                              input int sa, input int sb, input int sc, input int abort_at,
                              output int first_valid, output int done_cyc);
        int cyc;
        load_val    = val;
        acc_cnt     = 0;
        done_cnt    = 0;
        clr_cnt     = 0;
        ld_cnt      = 0;
        first_valid = 0;
        done_cyc    = 0;
        exp_q.delete();
        for (int i = 0; i < W; i++) exp_q.push_back(beat_t'{data: val[i], last: (i == W - 1)});
        tx_if.tx_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 400) begin
            if (tx_if.tx_valid && first_valid == 0) first_valid = cyc;
            if (done && done_cyc == 0) done_cyc = cyc;
            if (abort_at > 0 && acc_cnt == abort_at) begin
                rst_n = 1'b0;
                break;
            end
            if (done_cyc != 0 && cyc >= done_cyc + 2) break;
            tx_if.tx_ready = toggle ? (cyc % 3 == 0) : 1'b1;
            start = (cyc == sa) || (cyc == sb) || (cyc == sc);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (abort_at == 0 && done_cyc == 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: no done within %0d cycles, required done", cyc);
        end
    endtask

    task automatic check_run(input string name, input int fv, input int dc,
                             input int want_fv, input int want_dc);
        tests++;
        if (fv !== want_fv) begin
            fails++;
            $display("FAIL %s first_valid: cycle %0d, required %0d", name, fv, want_fv);
        end
        tests++;
        if (dc !== want_dc) begin
            fails++;
            $display("FAIL %s done_cycle: cycle %0d, required %0d", name, dc, want_dc);
        end
    endtask

    task automatic check_counts(input string name);
        tests++;
        if (clr_cnt != 2 || ld_cnt != 1) begin
            fails++;
            $display("FAIL %s strobes: clr=%0d ld=%0d cycles, required clr=2 ld=1", name, clr_cnt, ld_cnt);
        end
        tests++;
        if (acc_cnt != W || exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s accepts: %0d (left %0d), required %0d (left 0)", name, acc_cnt, exp_q.size(), W);
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL %s done_count: %0d, required 1", name, done_cnt);
        end
    endtask

    task automatic test_reset();
        tx_if.tx_ready = 1'b0;
        start = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({lat_clr, lat_ld, tx_if.tx_valid, tx_if.tx_data, tx_if.tx_last, busy, done} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: %b, required 0000000",
                     {lat_clr, lat_ld, tx_if.tx_valid, tx_if.tx_data, tx_if.tx_last, busy, done});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({lat_clr, lat_ld, tx_if.tx_valid, tx_if.tx_data, tx_if.tx_last, busy, done} !== 7'b0) begin
                fails++;
                $display("FAIL idle_outputs cycle %0d: %b, required 0000000", i,
                         {lat_clr, lat_ld, tx_if.tx_valid, tx_if.tx_data, tx_if.tx_last, busy, done});
            end
        end
    endtask

    task automatic test_nominal();
        int fv, dc;
        run_stream(16'hA5C3, 1'b0, 0, 0, 0, 0, fv, dc);
        check_run("nominal", fv, dc, 8, 24);
        check_counts("nominal");
    endtask

    task automatic test_backpressure();
        int fv, dc;
        run_stream(16'h8001, 1'b1, 0, 0, 0, 0, fv, dc);
        check_counts("backpressure");
        tests++;
        if (dc <= 24) begin
            fails++;
            $display("FAIL backpressure done_cycle: %0d, required later than 24", dc);
        end
    endtask

    task automatic test_start_while_busy();
        int fv, dc;
        // Extra starts land in SETTLE (5), SHIFT (12) and FIN (24).
        run_stream(16'h1234, 1'b0, 5, 12, 24, 0, fv, dc);
        check_run("busy_start", fv, dc, 8, 24);
        check_counts("busy_start");
        repeat (12) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || clr_cnt != 2) begin
            fails++;
            $display("FAIL busy_start requeue: busy=%b clr=%0d, required busy=0 clr=2", busy, clr_cnt);
        end
    endtask

    task automatic test_reset_mid_shift();
        int fv, dc;
        run_stream(16'h3C5A, 1'b0, 0, 0, 0, 5, fv, dc);
        #1;
        tests++;
        if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || lat_clr !== 1'b0 || lat_ld !== 1'b0) begin
            fails++;
            $display("FAIL abort_outputs: valid=%b busy=%b clr=%b ld=%b, required all 0",
                     tx_if.tx_valid, busy, lat_clr, lat_ld);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (done_cnt != 0 || acc_cnt != 5) begin
            fails++;
            $display("FAIL abort_done: done=%0d accepts=%0d, required done=0 accepts=5", done_cnt, acc_cnt);
        end
        run_stream(16'h00FF, 1'b0, 0, 0, 0, 0, fv, dc);
        check_run("after_abort", fv, dc, 8, 24);
        check_counts("after_abort");
    endtask

    task automatic test_clear();
        int fv, dc;
        run_stream(16'hFFFF, 1'b0, 0, 0, 0, 0, fv, dc);
        check_counts("preload_ones");
        run_stream(16'h0000, 1'b0, 0, 0, 0, 0, fv, dc);
        check_run("clear", fv, dc, 8, 24);
        check_counts("clear");
    endtask

    initial begin
        tx_if.tx_ready = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_shift();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
